// File: rtl/fft_peak_finder_pkg.sv
// fft_peak_finder_pkg: shared FSM state, magnitude type and L1 magnitude helper for the peak finder
package fft_peak_pkg;
  localparam int DEF_ADDR_W  = 11;
  localparam int DEF_DATA_W  = 10;
  localparam int DEF_NBINS   = 1024;
  localparam int DEF_MIN_BIN = 1;
  localparam int DEF_MIN_MAG = 16;
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
  typedef logic [DEF_DATA_W:0] mag_t;
  function automatic mag_t abs_l1(input logic signed [DEF_DATA_W-1:0] re,
                                  input logic signed [DEF_DATA_W-1:0] im);
    logic signed [DEF_DATA_W:0] r, i;
    r = re;
    i = im;
    return mag_t'(r < 0 ? -r : r) + mag_t'(i < 0 ? -i : i);
  endfunction
endpackage

// File: rtl/fft_peak_finder_if.sv
// fft_peak_finder_if: start/result handshake plus the shared sample-memory read port
interface fft_peak_finder_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 10
) ();
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [DATA_W-1:0] mem_data;
  logic [ADDR_W-2:0] peak_bin;
  logic [DATA_W:0]   peak_mag;
  logic              peak_valid;
  modport slave (
    input  start, mem_data,
    output busy, done, mem_addr, mem_rd_en, peak_bin, peak_mag, peak_valid
  );
  modport master (
    output start, mem_data,
    input  busy, done, mem_addr, mem_rd_en, peak_bin, peak_mag, peak_valid
  );
endinterface

// File: rtl/fft_peak_finder_cplx_mag_l1.sv
// cplx_mag_l1: combinational |re|+|im| of a signed complex word, one bit wider so the extremes never wrap
module cplx_mag_l1 #(
  parameter int W = 10
) (
  input  logic signed [W-1:0] re,
  input  logic signed [W-1:0] im,
  output logic        [W:0]   mag
);
  logic signed [W:0] re_x, im_x;
  always_comb begin
    re_x = re;
    im_x = im;
    mag  = (W+1)'(re_x < 0 ? -re_x : re_x) + (W+1)'(im_x < 0 ? -im_x : im_x);
  end
endmodule

// File: rtl/fft_peak_finder.sv
// fft_peak_finder: scans FFT bins in sample memory and reports the strongest bin and its L1 magnitude.
// Define PEAK_THRESHOLD_EN to gate peak_valid on peak_mag >= MIN_MAG.
module fft_peak_finder
  import fft_peak_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int NBINS   = DEF_NBINS,
  parameter int MIN_BIN = DEF_MIN_BIN,
  parameter int MIN_MAG = DEF_MIN_MAG
) (
  input logic              clk,
  input logic              rst,
  fft_peak_finder_if.slave bus
);
`ifdef PEAK_THRESHOLD_EN
  localparam bit THR_EN = 1'b1;
`else
  localparam bit THR_EN = 1'b0;
`endif
  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(2 * MIN_BIN);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(2 * NBINS - 1);
  state_t              state, nxt_state;
  logic [ADDR_W-1:0]   addr_q, ret_addr_q;
  logic                ret_vld_q, ret_im, upd, first_q;
  logic signed [DATA_W-1:0] re_q;
  logic [DATA_W:0]     mag, max_q, nxt_max;
  logic [ADDR_W-2:0]   bin_q, nxt_bin;
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt_state;
  end
  always_comb begin
    nxt_state = (state == IDLE && bus.start)              ? SCAN  :
                (state == SCAN && addr_q == LAST_ADDR)    ? DRAIN :
                (state == DRAIN)                          ? DONE  :
                (state == DONE)                           ? IDLE  : state;
  end
  always_comb begin
    bus.busy      = state != IDLE;
    bus.done      = state == DONE;
    bus.mem_rd_en = state == SCAN;
    bus.mem_addr  = state == SCAN ? addr_q : '0;
  end
  cplx_mag_l1 #(.W(DATA_W)) u_mag (
    .re  (re_q),
    .im  (bus.mem_data),
    .mag (mag)
  );
  // The im word of a bin returns on an odd address; compare it in the same cycle.
  always_comb begin
    ret_im  = ret_vld_q && ret_addr_q[0];
    upd     = ret_im && (first_q || mag > max_q);
    nxt_max = upd ? mag : max_q;
    nxt_bin = upd ? ret_addr_q[ADDR_W-1:1] : bin_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q         <= '0;
      ret_addr_q     <= '0;
      ret_vld_q      <= 1'b0;
      re_q           <= '0;
      max_q          <= '0;
      bin_q          <= '0;
      first_q        <= 1'b0;
      bus.peak_bin   <= '0;
      bus.peak_mag   <= '0;
      bus.peak_valid <= 1'b0;
    end else begin
      ret_vld_q  <= state == SCAN;
      ret_addr_q <= addr_q;
      if (state == IDLE && bus.start) begin
        addr_q  <= FIRST_ADDR;
        max_q   <= '0;
        bin_q   <= '0;
        first_q <= 1'b1;
      end else begin
        if (state == SCAN) addr_q <= addr_q + 1'b1;
        if (ret_im) begin
          max_q   <= nxt_max;
          bin_q   <= nxt_bin;
          first_q <= 1'b0;
        end
      end
      if (ret_vld_q && !ret_addr_q[0]) re_q <= bus.mem_data;
      // Results land at the end of DRAIN so they are visible in the DONE cycle.
      if (state == DRAIN) begin
        bus.peak_bin   <= nxt_bin;
        bus.peak_mag   <= nxt_max;
        bus.peak_valid <= !THR_EN || nxt_max >= (DATA_W+1)'(MIN_MAG);
      end
    end
  end
endmodule

// File: tb/tb_fft_peak_finder.sv
// tb_fft_peak_finder: scoreboard bench for fft_peak_finder (full 1024-bin instance plus an 8-bin timing instance)
module tb_fft_peak_finder;
  typedef struct {int bin; int mag; bit valid;} exp_t;
`ifdef PEAK_THRESHOLD_EN
  localparam bit THR = 1'b1;
`else
  localparam bit THR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  exp_t sb[$];
  logic signed [9:0] mem_b [2048];
  logic signed [9:0] mem_s [16];

  always #5 clk = ~clk;

  fft_peak_finder_if #(.ADDR_W(11), .DATA_W(10)) b_if ();
  fft_peak_finder_if #(.ADDR_W(4),  .DATA_W(10)) s_if ();

  fft_peak_finder #(.ADDR_W(11), .DATA_W(10), .NBINS(1024), .MIN_BIN(1), .MIN_MAG(16)) u_big (
    .clk (clk), .rst (rst), .bus (b_if.slave));
  fft_peak_finder #(.ADDR_W(4), .DATA_W(10), .NBINS(8), .MIN_BIN(1), .MIN_MAG(16)) u_small (
    .clk (clk), .rst (rst), .bus (s_if.slave));

  always @(posedge clk) begin
    if (b_if.mem_rd_en) b_if.mem_data <= mem_b[b_if.mem_addr];
    if (s_if.mem_rd_en) s_if.mem_data <= mem_s[s_if.mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (b_if.done) begin
      if (sb.size() == 0) check("unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("peak_bin", 32'(b_if.peak_bin), e.bin);
        check("peak_mag", 32'(b_if.peak_mag), e.mag);
        check("peak_valid", 32'(b_if.peak_valid), 32'(e.valid));
      end
    end
  end

  task automatic clear_big();
    for (int i = 0; i < 2048; i++) mem_b[i] = '0;
  endtask

  task automatic pulse_start();
    @(negedge clk) b_if.start = 1'b1;
    @(negedge clk) b_if.start = 1'b0;
  endtask

  task automatic run_scan(input int bin, input int mag);
    exp_t e;
    bit seen;
    e.bin = bin;
    e.mag = mag;
    e.valid = THR ? (mag >= 16) : 1'b1;
    sb.push_back(e);
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 2200 && !seen; i++) begin
      @(negedge clk);
      seen = b_if.done;
    end
    if (!seen) check("done_timeout", 0, 1);
    @(negedge clk);
    check("sb_empty", sb.size(), 0);
    check("busy_after", 32'(b_if.busy), 0);
  endtask

  initial begin
    b_if.start = 1'b0;
    s_if.start = 1'b0;
    clear_big();
    for (int i = 0; i < 16; i++) mem_s[i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 32'(b_if.busy), 0);
    check("rst_done", 32'(b_if.done), 0);
    check("rst_rd_en", 32'(b_if.mem_rd_en), 0);
    check("rst_addr", 32'(b_if.mem_addr), 0);
    check("rst_bin", 32'(b_if.peak_bin), 0);
    check("rst_mag", 32'(b_if.peak_mag), 0);
    check("rst_valid", 32'(b_if.peak_valid), 0);
    check("rst_s_busy", 32'(s_if.busy), 0);

    // small instance: exact cycle timing, with a start pulse mid-scan that must be ignored
    mem_s[6] = 10'sd7;
    mem_s[7] = -10'sd2;
    s_if.start = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      check("t_busy", 32'(s_if.busy), 32'(c <= 16));
      check("t_rd_en", 32'(s_if.mem_rd_en), 32'(c <= 14));
      check("t_addr", 32'(s_if.mem_addr), c <= 14 ? c + 1 : 0);
      check("t_done", 32'(s_if.done), 32'(c == 16));
      if (c == 16) begin
        check("t_bin", 32'(s_if.peak_bin), 3);
        check("t_mag", 32'(s_if.peak_mag), 9);
        check("t_valid", 32'(s_if.peak_valid), 32'(!THR));
      end
      s_if.start = (c == 5);
    end
    s_if.start = 1'b0;

    clear_big();
    mem_b[74] = 10'sd200;
    mem_b[75] = -10'sd150;
    run_scan(37, 350);

    clear_big();
    mem_b[20] = 10'sd100;
    mem_b[40] = 10'sd100;
    run_scan(10, 100);

    clear_big();
    mem_b[0]  = 10'sd511;
    mem_b[10] = -10'sd512;
    mem_b[11] = -10'sd512;
    run_scan(5, 1024);

    clear_big();
    mem_b[6] = 10'sd10;
    mem_b[7] = 10'sd5;
    run_scan(3, 15);

    clear_big();
    run_scan(1, 0);

    // reset in the middle of a scan: abort, clear outputs, then a fresh scan must still work
    mem_b[74] = 10'sd200;
    mem_b[75] = -10'sd150;
    pulse_start();
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", 32'(b_if.busy), 0);
    check("mid_rst_done", 32'(b_if.done), 0);
    check("mid_rst_bin", 32'(b_if.peak_bin), 0);
    check("mid_rst_mag", 32'(b_if.peak_mag), 0);
    check("mid_rst_valid", 32'(b_if.peak_valid), 0);
    repeat (20) @(negedge clk);
    check("mid_rst_idle", 32'(b_if.busy), 0);
    run_scan(37, 350);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
